// File: rtl/full_err_seq_pkg.sv
// full_err_seq_pkg: shared types for the FC error-stage sequencer.
// Holds the float word layout, the FSM state enum and skid width.
package full_err_seq_pkg;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_24_8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } full_err_seq_state_e;

  // skid entry = {fst, 32-bit memory word}
  localparam int SKID_W = 33;

  function automatic float_24_8 to_float(
    input logic [31:0] w
  );
    return float_24_8'(w);
  endfunction

endpackage

// File: rtl/full_err_skid2.sv
// full_err_skid2: 2-entry valid/ready FIFO. in_vld pushes in_data;
// out_data/out_vld present the head, popped on out_vld & out_rdy.
module full_err_skid2
  import full_err_seq_pkg::*;
#(
  parameter int W = SKID_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         pop,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  assign out_vld  = occ != 2'd0;
  assign pop      = out_vld && out_rdy;
  // head slot is never written while occupied, so it holds on stall
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (in_vld) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(in_vld) - 2'(pop);
    end
  end

endmodule

// File: rtl/full_err_seq.sv
// full_err_seq: streams expected vectors from memory to the error
// block (expected/_vld/_fst, rdy back-pressure) and counts zctrl_vld.
module full_err_seq
  import full_err_seq_pkg::*;
#(
  parameter int VEC_LEN = 36,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       cfg_num_samples,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              exp_mem_rd_vld,
  output logic [ADDR_W-1:0] exp_mem_rd_address,
  input  logic [31:0]       exp_mem_rd_data,
  output float_24_8         expected,
  output logic              expected_vld,
  output logic              expected_fst,
  input  logic              expected_rdy,
  input  logic              zctrl_vld,
  output logic              busy,
  output logic              sample_done,
  output logic [15:0]       sample_index,
  output logic              done,
  output logic              err_unexpected
);

  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(VEC_LEN - 1);

  full_err_seq_state_e state_q;

  logic [15:0]       n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [EW-1:0]     iss_elem;
  logic [15:0]       iss_sample;
  logic [EW-1:0]     rx_elem;
  logic              infl_q;
  logic              infl_fst_q;

  logic [SKID_W-1:0] head;
  logic [1:0]        occ;
  logic              pop;
  logic              issue;
  logic              last_issue;
  logic              drained;

  full_err_skid2 #(.W(SKID_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (infl_q),
    .in_data  ({infl_fst_q, exp_mem_rd_data}),
    .out_rdy  (expected_rdy),
    .out_vld  (expected_vld),
    .out_data (head),
    .pop      (pop),
    .occ      (occ)
  );

  assign expected_fst = head[SKID_W-1];
  assign expected     = to_float(head[31:0]);

  assign busy = (state_q == ST_STREAM)
             || (state_q == ST_DRAIN);

  // occupancy + in-flight never exceeds the 2 skid slots
  assign issue = (state_q == ST_STREAM)
              && (((occ + 2'(infl_q)) < 2'd2) || pop);

  assign last_issue = issue
                   && (iss_elem == ELEM_LAST)
                   && (iss_sample == n_q - 16'd1);

  assign drained = !expected_vld && !infl_q
                && (sample_index == n_q);

  assign exp_mem_rd_vld     = issue;
  assign exp_mem_rd_address = addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      addr_q         <= '0;
      iss_elem       <= '0;
      iss_sample     <= '0;
      rx_elem        <= '0;
      infl_q         <= 1'b0;
      infl_fst_q     <= 1'b0;
      sample_index   <= '0;
      sample_done    <= 1'b0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      done        <= 1'b0;
      infl_q      <= issue;
      infl_fst_q  <= (iss_elem == '0);

      if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (iss_elem == ELEM_LAST) begin
          iss_elem   <= '0;
          iss_sample <= iss_sample + 16'd1;
        end else begin
          iss_elem <= iss_elem + EW'(1);
        end
      end

      if (zctrl_vld && busy) begin
        if (rx_elem == ELEM_LAST) begin
          rx_elem      <= '0;
          sample_done  <= 1'b1;
          sample_index <= sample_index + 16'd1;
        end else begin
          rx_elem <= rx_elem + EW'(1);
        end
      end

      if (zctrl_vld && !busy) err_unexpected <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q            <= cfg_num_samples;
            addr_q         <= cfg_base_addr;
            iss_elem       <= '0;
            iss_sample     <= '0;
            rx_elem        <= '0;
            sample_index   <= '0;
            // a stray result in the start cycle still counts
            err_unexpected <= zctrl_vld;
            state_q <= (cfg_num_samples == 16'd0)
                     ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (last_issue) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drained) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_full_err_seq.sv
// tb_full_err_seq: random-stimulus bench for full_err_seq with a
// memory model, a result-return model and a stream reference model.
module tb_full_err_seq;
  import full_err_seq_pkg::*;

  localparam int VEC_LEN = 36;
  localparam int ADDR_W  = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       cfg_num_samples = '0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic              exp_mem_rd_vld;
  logic [ADDR_W-1:0] exp_mem_rd_address;
  logic [31:0]       exp_mem_rd_data = '0;
  float_24_8         expected;
  logic              expected_vld;
  logic              expected_fst;
  logic              expected_rdy = 1'b0;
  logic              zctrl_vld;
  logic              busy;
  logic              sample_done;
  logic [15:0]       sample_index;
  logic              done;
  logic              err_unexpected;

  logic       zforce = 1'b0;
  logic       zen = 1'b1;
  logic [3:0] zpipe = '0;

  int checks = 0;
  int errors = 0;

  logic [32:0]       acc_q [$];
  logic [ADDR_W-1:0] rd_q  [$];
  int sd_cnt = 0;
  int done_cnt = 0;
  int done_busy = 0;
  int busy_cnt = 0;

  full_err_seq #(.VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .cfg_num_samples    (cfg_num_samples),
    .cfg_base_addr      (cfg_base_addr),
    .exp_mem_rd_vld     (exp_mem_rd_vld),
    .exp_mem_rd_address (exp_mem_rd_address),
    .exp_mem_rd_data    (exp_mem_rd_data),
    .expected           (expected),
    .expected_vld       (expected_vld),
    .expected_fst       (expected_fst),
    .expected_rdy       (expected_rdy),
    .zctrl_vld          (zctrl_vld),
    .busy               (busy),
    .sample_done        (sample_done),
    .sample_index       (sample_index),
    .done               (done),
    .err_unexpected     (err_unexpected)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(
    input logic [ADDR_W-1:0] a
  );
    return {a, 8'h5A, ~a[7:0], 4'h3};
  endfunction

  // k-th element of a run: address base+k mod 4096, fst on e==0
  function automatic logic [32:0] model_elem(
    input int k, input logic [ADDR_W-1:0] base
  );
    logic [ADDR_W-1:0] a;
    a = base + ADDR_W'(k);
    return {(k % VEC_LEN) == 0, word_of(a)};
  endfunction

  // one-cycle-latency expected-value memory
  always @(posedge clk)
    if (exp_mem_rd_vld)
      exp_mem_rd_data <= word_of(exp_mem_rd_address);

  // error block: one result per accepted element, 3 cycles later
  always @(negedge clk)
    if (!reset) zpipe <= '0;
    else zpipe <= {zpipe[2:0],
                   zen && expected_vld && expected_rdy};

  assign zctrl_vld = zforce | zpipe[3];

  always @(negedge clk) begin
    if (expected_vld && expected_rdy)
      acc_q.push_back({expected_fst, expected});
    if (exp_mem_rd_vld) rd_q.push_back(exp_mem_rd_address);
    if (sample_done) sd_cnt++;
    if (done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
    if (busy) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    rd_q.delete();
    sd_cnt = 0;
    done_cnt = 0;
    done_busy = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse_start(
    input logic [15:0] n, input logic [ADDR_W-1:0] b
  );
    cfg_num_samples = n;
    cfg_base_addr = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({exp_mem_rd_vld, expected_vld, expected_fst, busy,
         sample_done, done, err_unexpected} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
        {exp_mem_rd_vld, expected_vld, expected_fst, busy,
         sample_done, done, err_unexpected});
    end
    checks++;
    if (expected !== 32'h0) begin
      errors++;
      $display("FAIL reset_expected got %h want 0", expected);
    end
    checks++;
    if (sample_index !== 16'd0) begin
      errors++;
      $display("FAIL reset_index got %0d want 0", sample_index);
    end
    checks++;
    if (exp_mem_rd_address !== '0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0",
        exp_mem_rd_address);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    expected_rdy = 1'b1;
    pulse_start(16'd2, 12'h010);
    @(negedge clk);
    checks++;
    if ({exp_mem_rd_vld, busy, expected_vld} !== 3'b110
        || exp_mem_rd_address !== 12'h010) begin
      errors++;
      $display("FAIL first_read got rd=%b busy=%b vld=%b a=%h",
        exp_mem_rd_vld, busy, expected_vld, exp_mem_rd_address);
    end
    @(negedge clk);
    checks++;
    if (expected_vld !== 1'b0) begin
      errors++;
      $display("FAIL vld_early got %b want 0", expected_vld);
    end
    @(negedge clk);
    checks++;
    if (expected_vld !== 1'b1
        || {expected_fst, expected} !== model_elem(0, 12'h010)) begin
      errors++;
      $display("FAIL first_vld got vld=%b d=%h want %h",
        expected_vld, {expected_fst, expected},
        model_elem(0, 12'h010));
    end
    wait_done(500, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_timeout got no done");
    end
    checks++;
    if (rd_q.size() !== 72 || acc_q.size() !== 72) begin
      errors++;
      $display("FAIL basic_count got rd=%0d acc=%0d want 72",
        rd_q.size(), acc_q.size());
    end
    for (int k = 0; k < rd_q.size() && k < 72; k++) begin
      checks++;
      if (rd_q[k] !== ADDR_W'(12'h010 + k)) begin
        errors++;
        $display("FAIL basic_addr[%0d] got %h want %h",
          k, rd_q[k], ADDR_W'(12'h010 + k));
      end
    end
    for (int k = 0; k < acc_q.size() && k < 72; k++) begin
      checks++;
      if (acc_q[k] !== model_elem(k, 12'h010)) begin
        errors++;
        $display("FAIL basic_elem[%0d] got %h want %h",
          k, acc_q[k], model_elem(k, 12'h010));
      end
    end
    checks++;
    if (sd_cnt !== 2 || sample_index !== 16'd2) begin
      errors++;
      $display("FAIL basic_samples got sd=%0d idx=%0d want 2",
        sd_cnt, sample_index);
    end
    checks++;
    if (done_cnt !== 1 || done_busy !== 0) begin
      errors++;
      $display("FAIL basic_done got cnt=%0d with_busy=%0d",
        done_cnt, done_busy);
    end
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %b want 0", err_unexpected);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit prev_stall;
    logic [32:0] prev;
    logic [ADDR_W-1:0] base;
    clear_mon();
    ok = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    base = 12'h200 + 12'($urandom_range(0, 255));
    pulse_start(16'd1, base);
    for (int i = 0; i < 1000; i++) begin
      expected_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (expected_vld !== 1'b1
            || {expected_fst, expected} !== prev) begin
          errors++;
          $display("FAIL stall_hold got vld=%b d=%h want %h",
            expected_vld, {expected_fst, expected}, prev);
        end
      end
      prev_stall = expected_vld && !expected_rdy;
      prev = {expected_fst, expected};
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    expected_rdy = 1'b1;
    repeat (6) step();
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got no done");
    end
    checks++;
    if (acc_q.size() !== VEC_LEN || rd_q.size() !== VEC_LEN) begin
      errors++;
      $display("FAIL bp_count got acc=%0d rd=%0d want %0d",
        acc_q.size(), rd_q.size(), VEC_LEN);
    end
    for (int k = 0; k < acc_q.size() && k < VEC_LEN; k++) begin
      checks++;
      if (acc_q[k] !== model_elem(k, base)) begin
        errors++;
        $display("FAIL bp_elem[%0d] got %h want %h",
          k, acc_q[k], model_elem(k, base));
      end
    end
    checks++;
    if (sample_index !== 16'd1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_end got idx=%0d done=%0d want 1/1",
        sample_index, done_cnt);
    end
  endtask

  task automatic test_wrap_and_zero();
    bit ok;
    clear_mon();
    expected_rdy = 1'b1;
    pulse_start(16'd1, 12'hFF0);
    wait_done(300, ok);
    checks++;
    if (ok !== 1'b1 || rd_q.size() !== VEC_LEN) begin
      errors++;
      $display("FAIL wrap_run got ok=%b rd=%0d want 1/%0d",
        ok, rd_q.size(), VEC_LEN);
    end
    if (rd_q.size() > 16) begin
      checks++;
      if (rd_q[15] !== 12'hFFF || rd_q[16] !== 12'h000) begin
        errors++;
        $display("FAIL wrap_addr got %h,%h want fff,000",
          rd_q[15], rd_q[16]);
      end
    end
    for (int k = 0; k < acc_q.size() && k < VEC_LEN; k++) begin
      checks++;
      if (acc_q[k] !== model_elem(k, 12'hFF0)) begin
        errors++;
        $display("FAIL wrap_elem[%0d] got %h want %h",
          k, acc_q[k], model_elem(k, 12'hFF0));
      end
    end
    clear_mon();
    pulse_start(16'd0, 12'h123);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_e1 got done=%b busy=%b want 0/0",
        done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_e2 got done=%b busy=%b want 1/0",
        done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_e3 got done=%b want 0", done);
    end
    repeat (3) step();
    checks++;
    if (busy_cnt !== 0 || done_cnt !== 1 || rd_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_run got busy=%0d done=%0d rd=%0d",
        busy_cnt, done_cnt, rd_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    clear_mon();
    expected_rdy = 1'b1;
    pulse_start(16'd3, 12'h100);
    for (int i = 0; i < 200 && acc_q.size() < 20; i++) step();
    checks++;
    if (acc_q.size() < 20) begin
      errors++;
      $display("FAIL mid_reach got %0d want 20", acc_q.size());
    end
    reset = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({exp_mem_rd_vld, expected_vld, expected_fst, busy,
         sample_done, done, err_unexpected} !== 7'b0
        || expected !== 32'h0 || sample_index !== 16'd0
        || exp_mem_rd_address !== '0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b d=%h idx=%0d a=%h",
        {exp_mem_rd_vld, expected_vld, expected_fst, busy,
         sample_done, done, err_unexpected},
        expected, sample_index, exp_mem_rd_address);
    end
    step();
    reset = 1'b1;
    repeat (5) step();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone got done=%0d busy=%b want 0/0",
        done_cnt, busy);
    end
    clear_mon();
    pulse_start(16'd1, 12'h300);
    @(negedge clk);
    checks++;
    if (exp_mem_rd_vld !== 1'b1
        || exp_mem_rd_address !== 12'h300) begin
      errors++;
      $display("FAIL restart_addr got rd=%b a=%h want 1/300",
        exp_mem_rd_vld, exp_mem_rd_address);
    end
    wait_done(300, ok);
    checks++;
    if (ok !== 1'b1 || acc_q.size() !== VEC_LEN) begin
      errors++;
      $display("FAIL restart_run got ok=%b acc=%0d",
        ok, acc_q.size());
    end
    for (int k = 0; k < acc_q.size() && k < VEC_LEN; k++) begin
      checks++;
      if (acc_q[k] !== model_elem(k, 12'h300)) begin
        errors++;
        $display("FAIL restart_elem[%0d] got %h want %h",
          k, acc_q[k], model_elem(k, 12'h300));
      end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    clear_mon();
    expected_rdy = 1'b1;
    zforce = 1'b1;
    step();
    zforce = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", err_unexpected);
    end
    repeat (4) step();
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b1 || sample_index !== 16'd1
        || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_hold got err=%b idx=%0d busy=%b",
        err_unexpected, sample_index, busy);
    end
    step();
    pulse_start(16'd1, 12'h040);
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err_unexpected);
    end
    for (int i = 0; i < 100 && acc_q.size() < 10; i++) step();
    cfg_num_samples = 16'd5;
    cfg_base_addr = 12'h800;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(300, ok);
    checks++;
    if (ok !== 1'b1 || acc_q.size() !== VEC_LEN
        || rd_q.size() !== VEC_LEN) begin
      errors++;
      $display("FAIL busy_start got ok=%b acc=%0d rd=%0d",
        ok, acc_q.size(), rd_q.size());
    end
    for (int k = 0; k < acc_q.size() && k < VEC_LEN; k++) begin
      checks++;
      if (acc_q[k] !== model_elem(k, 12'h040)) begin
        errors++;
        $display("FAIL busy_elem[%0d] got %h want %h",
          k, acc_q[k], model_elem(k, 12'h040));
      end
    end
    checks++;
    if (sample_index !== 16'd1 || done_cnt !== 1
        || err_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL busy_end got idx=%0d done=%0d err=%b",
        sample_index, done_cnt, err_unexpected);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap_and_zero();
    test_reset_mid_run();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
